// File: rtl/data_mem_responder.sv
// Slow data-memory responder for the MEM stage: 2^ADDR_W x 32 array with byte
// write enables, answering each accepted request with a one-cycle mres after LATENCY cycles.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mreq,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mres,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] rdata_reg;
    logic        mres_reg;
    logic        busy_reg;
    logic        accept;
    logic [3:0]  byte_we;

    logic [31:0] mem [2**ADDR_W];

    // Reset wins over a same-cycle request, so an aborted accept never writes.
    assign accept = (state_reg == IDLE) && mreq && !reset;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_we[gi] = accept & wen[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            rdata_reg <= 32'd0;
            mres_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mreq) begin
                        busy_reg  <= 1'b1;
                        rdata_reg <= (wen != 4'd0) ? 32'd0 : mem[addr];
                        if (LATENCY == 1) begin
                            state_reg <= RESP;
                            mres_reg  <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= RESP;
                        mres_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    mres_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    mres_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = rdata_reg;
    assign mres  = mres_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives three responder builds (LATENCY 2, 1, 15) with shared inputs and checks
// timing and data against a word/byte memory model kept in the bench.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mreq;
    logic [3:0]  wen;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  mres_v;
    logic [2:0]  busy_v;
    logic [31:0] rdata_v [3];

    int lat_v [3] = '{2, 1, 15};
    int passed = 0;
    int total  = 0;

    logic [31:0] model [256];
    bit          valid [256];

    typedef struct {
        logic [3:0]  wen;
        logic [7:0]  addr;
        logic [31:0] wdata;
        bit          pulse;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .mreq(mreq), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[0]), .mres(mres_v[0]), .busy(busy_v[0]));
    data_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .mreq(mreq), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[1]), .mres(mres_v[1]), .busy(busy_v[1]));
    data_mem_responder #(.ADDR_W(8), .LATENCY(15)) dut15 (
        .clk(clk), .reset(reset), .mreq(mreq), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[2]), .mres(mres_v[2]), .busy(busy_v[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else passed++;
    endtask

    task automatic model_write(input logic [3:0] w, input logic [7:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (w[i]) model[a][8*i +: 8] = d[8*i +: 8];
        valid[a] = 1'b1;
    endtask

    // Called at a negedge with every build idle; returns at a negedge.
    task automatic txn(input logic [3:0] w, input logic [7:0] a, input logic [31:0] d,
                       input bit pulse, input logic [31:0] exp, input string tag);
        int first [3];
        int cnt [3];
        int bcnt [3];
        logic [31:0] got [3];
        for (int i = 0; i < 3; i++) begin
            first[i] = -1; cnt[i] = 0; bcnt[i] = 0; got[i] = 32'hx;
        end
        mreq = 1'b1; wen = w; addr = a; wdata = d;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (mres_v[i]) begin
                    cnt[i]++;
                    if (first[i] < 0) begin
                        first[i] = k;
                        got[i] = rdata_v[i];
                    end
                end
                if (busy_v[i]) bcnt[i]++;
            end
            if (k == 1) mreq = pulse;
            else mreq = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_L%0d_mres_cycle", tag, lat_v[i]), first[i], lat_v[i]);
            chk($sformatf("%s_L%0d_mres_count", tag, lat_v[i]), cnt[i], 1);
            chk($sformatf("%s_L%0d_busy_cycles", tag, lat_v[i]), bcnt[i], lat_v[i]);
            chk($sformatf("%s_L%0d_rdata", tag, lat_v[i]), got[i], exp);
        end
        if (w != 4'd0) model_write(w, a, d);
        $display("txn %s wen=%h addr=%h wdata=%h exp=%h got=%h/%h/%h",
                 tag, w, a, d, exp, got[0], got[1], got[2]);
    endtask

    initial begin
        int pulses;
        int busy_cnt;
        int pc [$];
        logic [31:0] pd [$];

        vecs[0]  = '{4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{4'h0, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{4'hF, 8'h20, 32'h11223344, 1'b0, 32'h0};
        vecs[3]  = '{4'h5, 8'h20, 32'hAABBCCDD, 1'b0, 32'h0};
        vecs[4]  = '{4'h0, 8'h20, 32'h0,        1'b0, 32'h11BB33DD};
        vecs[5]  = '{4'hF, 8'hFF, 32'h000000FF, 1'b0, 32'h0};
        vecs[6]  = '{4'hF, 8'h00, 32'h00000100, 1'b0, 32'h0};
        vecs[7]  = '{4'h0, 8'hFF, 32'h0,        1'b0, 32'h000000FF};
        vecs[8]  = '{4'h0, 8'h00, 32'h0,        1'b0, 32'h00000100};
        vecs[9]  = '{4'hF, 8'h40, 32'h12345678, 1'b0, 32'h0};
        vecs[10] = '{4'h0, 8'h40, 32'h0,        1'b1, 32'h12345678};

        reset = 1'b1; mreq = 1'b0; wen = 4'h0; addr = 8'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_L%0d_busy", lat_v[i]), busy_v[i], 0);
            chk($sformatf("reset_L%0d_mres", lat_v[i]), mres_v[i], 0);
            chk($sformatf("reset_L%0d_rdata", lat_v[i]), rdata_v[i], 0);
        end
        $display("txn reset busy=%b mres=%b", busy_v, mres_v);

        for (int v = 0; v < 11; v++)
            txn(vecs[v].wen, vecs[v].addr, vecs[v].wdata, vecs[v].pulse, vecs[v].exp,
                $sformatf("vec%0d", v));

        // Back-to-back reads with mreq held high; the LATENCY=2 build sets the schedule.
        mreq = 1'b1; wen = 4'h0; addr = 8'h10;
        busy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mres_v[0]) begin
                pc.push_back(c);
                pd.push_back(rdata_v[0]);
            end
            if (busy_v[0]) busy_cnt++;
            addr = (c <= 3) ? 8'h20 : 8'h10;
            if (c == 7) mreq = 1'b0;
        end
        chk("b2b_mres_count", pc.size(), 3);
        chk("b2b_busy_cycles", busy_cnt, 6);
        if (pc.size() == 3) begin
            chk("b2b_cycle0", pc[0], 2);
            chk("b2b_cycle1", pc[1], 5);
            chk("b2b_cycle2", pc[2], 8);
            chk("b2b_data0", pd[0], 32'hDEADBEEF);
            chk("b2b_data1", pd[1], 32'h11BB33DD);
            chk("b2b_data2", pd[2], 32'hDEADBEEF);
            $display("txn b2b mres@%0d,%0d,%0d data=%h,%h,%h", pc[0], pc[1], pc[2], pd[0], pd[1], pd[2]);
        end else begin
            $display("txn b2b mres pulses=%0d", pc.size());
        end
        chk("b2b_all_idle", busy_v, 3'b000);

        // Reset asserted in A+1 of a write: transaction aborts, write stays committed.
        mreq = 1'b1; wen = 4'hF; addr = 8'h30; wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstmid_L2_mres_a1", mres_v[0], 0);
        mreq = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rstmid_L%0d_busy", lat_v[i]), busy_v[i], 0);
            chk($sformatf("rstmid_L%0d_rdata", lat_v[i]), rdata_v[i], 0);
        end
        pulses = 0;
        for (int c = 2; c <= 18; c++) begin
            if (mres_v != 3'b000 || busy_v != 3'b000) pulses++;
            @(negedge clk);
        end
        chk("rstmid_no_activity", pulses, 0);
        $display("txn reset_mid_op activity_cycles=%0d", pulses);
        model_write(4'hF, 8'h30, 32'hCAFEF00D);
        txn(4'h0, 8'h30, 32'h0, 1'b0, model[8'h30], "rstmid_read");

        // Reset in cycle A: no accept and no array write.
        mreq = 1'b1; wen = 4'hF; addr = 8'h40; wdata = 32'hFFFFFFFF; reset = 1'b1;
        @(negedge clk);
        mreq = 1'b0; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rstA_L%0d_busy", lat_v[i]), busy_v[i], 0);
            chk($sformatf("rstA_L%0d_rdata", lat_v[i]), rdata_v[i], 0);
        end
        pulses = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (mres_v != 3'b000 || busy_v != 3'b000) pulses++;
        end
        chk("rstA_no_activity", pulses, 0);
        $display("txn reset_in_A activity_cycles=%0d", pulses);
        txn(4'h0, 8'h40, 32'h0, 1'b0, model[8'h40], "rstA_read");

        // Random mix of reads and partial/full writes against the model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0]  a;
            logic [3:0]  w;
            logic [31:0] d;
            logic [31:0] e;
            a = 8'($urandom_range(0, 255));
            d = $urandom;
            if (!valid[a] || $urandom_range(0, 1) == 1) begin
                w = valid[a] ? 4'($urandom_range(1, 15)) : 4'hF;
                e = 32'h0;
            end else begin
                w = 4'h0;
                e = model[a];
            end
            txn(w, a, d, 1'($urandom_range(0, 1)), e, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
